// File: rtl/dac_frame_streamer.sv
// dac_frame_streamer: assembles interleaved channel samples into frames, buffers them in a FIFO
// and releases one frame to all DAC code buses per programmable sample-rate tick.
module dac_frame_streamer #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         enable,
    input  logic [DIV_WIDTH-1:0]         div,
    input  logic                         signed_mode,
    input  logic                         underrun_mid,
    output logic [CHANNELS*WIDTH-1:0]    dac_code,
    output logic                         frame_strobe,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [7:0]                   underrun_count
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int FW = CHANNELS * WIDTH;

    logic [CW-1:0]        ch;
    logic [FW-1:0]        asm_frame, push_frame, head, conv, mid;
    logic [FW-1:0]        mem [DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [DIV_WIDTH-1:0] cnt;
    logic                 last, full, empty, xfer, push, tick, pop;

    assign last     = ch == CW'(CHANNELS - 1);
    assign full     = level == LW'(DEPTH);
    assign empty    = level == '0;
    assign in_ready = !(last && full);
    assign xfer     = in_valid && in_ready;
    assign push     = xfer && last;
    assign tick     = enable && cnt == '0;
    assign pop      = tick && !empty;
    assign head     = mem[rd_ptr];

    // The final sample bypasses the assembly register so the whole frame is pushed in one cycle.
    always_comb begin
        push_frame = asm_frame;
        push_frame[(CHANNELS-1)*WIDTH +: WIDTH] = in_data;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign conv[c*WIDTH +: WIDTH] = head[c*WIDTH +: WIDTH] ^ (WIDTH'(signed_mode) << (WIDTH - 1));
        assign mid[c*WIDTH +: WIDTH]  = WIDTH'(1) << (WIDTH - 1);
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= push_frame;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ch             <= '0;
            asm_frame      <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            cnt            <= '0;
            dac_code       <= mid;
            frame_strobe   <= 1'b0;
            underrun_count <= '0;
        end else begin
            if (xfer) begin
                asm_frame[ch*WIDTH +: WIDTH] <= in_data;
                ch <= last ? '0 : ch + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level        <= level + LW'(push) - LW'(pop);
            cnt          <= (!enable || tick) ? div : cnt - 1'b1;
            frame_strobe <= pop;
            if (pop) dac_code <= conv;
            else if (tick && underrun_mid) dac_code <= mid;
            if (tick && empty && underrun_count != 8'hff) underrun_count <= underrun_count + 1'b1;
        end
endmodule

// File: tb/tb_dac_frame_streamer.sv
// tb_dac_frame_streamer: directed bench with a frame scoreboard; expected codes are queued
// when a frame is sent and compared whenever frame_strobe is seen.
module tb_dac_frame_streamer;
    logic        clk = 0, rst = 1;
    logic [7:0]  in_data = 0;
    logic        in_valid = 0, in_ready;
    logic        enable = 0;
    logic [15:0] div = 16'd3;
    logic        signed_mode = 0, underrun_mid = 1;
    logic [15:0] dac_code;
    logic        frame_strobe;
    logic [2:0]  level;
    logic [7:0]  underrun_count;

    int checks = 0, failures = 0, strobes = 0;
    logic [15:0] q[$];

    dac_frame_streamer #(.CHANNELS(2), .WIDTH(8), .DEPTH(4), .DIV_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .enable(enable), .div(div), .signed_mode(signed_mode), .underrun_mid(underrun_mid),
        .dac_code(dac_code), .frame_strobe(frame_strobe), .level(level), .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (frame_strobe) begin
            strobes++;
            if (q.size() == 0) check("spurious_strobe", 32'(frame_strobe), 0);
            else check("frame_code", 32'(dac_code), 32'(q.pop_front()));
        end
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1;
        in_data  = d;
        check("send_ready", 32'(in_ready), 1);
        cyc();
        in_valid = 0;
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] m;
        m = signed_mode ? 8'h80 : 8'h00;
        q.push_back({b ^ m, a ^ m});
        send(a);
        send(b);
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin cyc(); n++; end while (!frame_strobe && n < 50);
    endtask

    task automatic wait_uc(output int n);
        logic [7:0] u;
        u = underrun_count;
        n = 0;
        do begin cyc(); n++; end while (underrun_count == u && n < 50);
    endtask

    initial begin
        int n;
        logic [7:0] u0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_dac", 32'(dac_code), 'h8080);
        check("rst_strobe", 32'(frame_strobe), 0);
        check("rst_level", 32'(level), 0);
        check("rst_uc", 32'(underrun_count), 0);
        check("rst_ready", 32'(in_ready), 1);

        // basic frames, div=3
        push_frame(8'h10, 8'h20);
        check("level_1", 32'(level), 1);
        push_frame(8'h30, 8'h40);
        check("level_2", 32'(level), 2);
        enable = 1;
        wait_strobe(n);
        check("first_tick_cycles", n, 4);
        check("dac_f1", 32'(dac_code), 'h2010);
        check("level_after_pop1", 32'(level), 1);
        wait_strobe(n);
        check("second_tick_cycles", n, 4);
        check("dac_f2", 32'(dac_code), 'h4030);
        check("level_after_pop2", 32'(level), 0);

        // underrun, hold then midscale, div=1
        enable = 0; div = 16'd1; cyc();
        check("uc_before", 32'(underrun_count), 0);
        underrun_mid = 0; enable = 1;
        repeat (6) cyc();
        check("uc_every2", 32'(underrun_count), 3);
        check("dac_hold", 32'(dac_code), 'h4030);
        underrun_mid = 1;
        repeat (2) cyc();
        check("uc_4", 32'(underrun_count), 4);
        check("dac_mid", 32'(dac_code), 'h8080);
        repeat (600) cyc();
        check("uc_sat", 32'(underrun_count), 255);
        check("no_strobe_underrun", strobes, 2);

        // full FIFO backpressure
        enable = 0; div = 16'd0; cyc();
        push_frame(8'h01, 8'h02);
        push_frame(8'h03, 8'h04);
        push_frame(8'h05, 8'h06);
        push_frame(8'h07, 8'h08);
        check("level_full", 32'(level), 4);
        send(8'h09);
        check("ready_low_final", 32'(in_ready), 0);
        in_valid = 1; in_data = 8'h0A;
        repeat (3) cyc();
        check("ready_still_low", 32'(in_ready), 0);
        check("level_still_full", 32'(level), 4);
        q.push_back(16'h0A09);
        enable = 1; cyc(); enable = 0;
        check("dac_pop_full", 32'(dac_code), 'h0201);
        check("ready_after_pop", 32'(in_ready), 1);
        cyc();
        in_valid = 0;
        check("level_refill", 32'(level), 4);
        enable = 1;
        repeat (5) cyc();
        enable = 0;
        check("dac_drain_mid", 32'(dac_code), 'h8080);
        check("level_drained", 32'(level), 0);
        check("queue_drained", q.size(), 0);
        check("strobes_drain", strobes, 7);

        // signed conversion
        signed_mode = 1;
        push_frame(8'h80, 8'h7F);
        enable = 1; cyc(); enable = 0;
        check("dac_signed", 32'(dac_code), 'hFF00);
        signed_mode = 0;

        // asynchronous reset mid-frame
        push_frame(8'h34, 8'h12);
        enable = 1; cyc(); enable = 0;
        push_frame(8'hA1, 8'hA2);
        push_frame(8'hB1, 8'hB2);
        push_frame(8'hC1, 8'hC2);
        send(8'h77);
        check("pre_rst_level", 32'(level), 3);
        check("pre_rst_dac", 32'(dac_code), 'h1234);
        #2 rst = 1;
        #1;
        check("arst_dac", 32'(dac_code), 'h8080);
        check("arst_level", 32'(level), 0);
        check("arst_uc", 32'(underrun_count), 0);
        check("arst_ready", 32'(in_ready), 1);
        check("arst_strobe", 32'(frame_strobe), 0);
        q.delete();
        @(posedge clk);
        #1 rst = 0;
        push_frame(8'h55, 8'h66);
        enable = 1; cyc(); enable = 0;
        check("post_rst_dac", 32'(dac_code), 'h6655);

        // disabled hold, then new divider
        div = 16'd3; cyc();
        u0 = underrun_count;
        repeat (10) cyc();
        check("disabled_no_tick", 32'(underrun_count), 32'(u0));
        check("disabled_dac", 32'(dac_code), 'h6655);
        div = 16'd5; cyc();
        enable = 1;
        wait_uc(n);
        check("div5_first", n, 6);
        wait_uc(n);
        check("div5_period", n, 6);
        enable = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
